// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and access-size codes for the fetch/data memory port arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // AddrMode: bit 2 selects zero-extension, bits 1:0 the access size.
    localparam logic [2:0] ADDRMODE_BYTE   = 3'b000;
    localparam logic [2:0] ADDRMODE_HALF   = 3'b001;
    localparam logic [2:0] ADDRMODE_WORD   = 3'b010;
    localparam logic [2:0] ADDRMODE_BYTE_U = 3'b100;
    localparam logic [2:0] ADDRMODE_HALF_U = 3'b101;

    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive fetch losses; at_limit forces the next fetch win.
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int LIMIT = 4,
    localparam int CW   = starve_cnt_width(LIMIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic          o_at_limit,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count == LIMIT_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_at_limit = w_at_limit;
    assign o_count    = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store; data wins unless fetch has starved.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = starve_cnt_width(STARVE_LIMIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            d_addrmode,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_addrmode,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_stray,
    output logic                  o_dbg_state,
    output logic                  o_dbg_owner,
    output logic [CNT_W-1:0]      o_dbg_starve_cnt
);

    // Handshake: a request is accepted in the cycle where mem_req & mem_ready are both
    // high (zero-latency issue from IDLE); exactly one mem_rvalid closes it from WAIT.

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_owner_t       r_owner;
    logic             w_at_limit;
    logic             w_win_d;
    logic             w_any_req;
    logic             w_grant;
    logic [CNT_W-1:0] w_starve_cnt;

    assign w_any_req = if_req | d_req;
    assign w_win_d   = d_req & ~(if_req & w_at_limit);
    assign w_grant   = (r_state == ARB_IDLE) & w_any_req & mem_ready;

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_grant & w_win_d & if_req),
        .i_clr     (w_grant & ~w_win_d),
        .o_at_limit(w_at_limit),
        .o_count   (w_starve_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant)    w_state_nxt = ARB_WAIT;
            ARB_WAIT: if (mem_rvalid) w_state_nxt = ARB_IDLE;
            default:                  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_IF;
        end else if (w_grant) begin
            r_owner <= w_win_d ? OWN_D : OWN_IF;
        end
    end

    // Everything is gated by rst so the port goes quiet the instant reset asserts.
    always_comb begin
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        if_rdata     = '0;
        d_rdata      = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_addrmode = 3'b000;
        err_stray    = 1'b0;
        if (rst) begin
            case (r_state)
                ARB_IDLE: begin
                    mem_req   = w_any_req;
                    if_gnt    = w_grant & ~w_win_d;
                    d_gnt     = w_grant & w_win_d;
                    err_stray = mem_rvalid;
                    if (w_win_d) begin
                        mem_we       = d_we;
                        mem_addr     = d_addr;
                        mem_wdata    = d_wdata;
                        mem_addrmode = d_addrmode;
                    end else begin
                        mem_addr     = if_addr;
                        mem_addrmode = ADDRMODE_WORD;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_owner == OWN_D) begin
                            d_rvalid = 1'b1;
                            d_rdata  = mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dbg_state      = r_state;
    assign o_dbg_owner      = r_owner;
    assign o_dbg_starve_cnt = w_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, random run vs model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIMIT = 4;
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [2:0] MODE_WORD = 3'b010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_req = 0, d_req = 0, d_we = 0, mem_ready = 0, mem_rvalid = 0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [2:0] d_addrmode = '0;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err_stray;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [2:0] mem_addrmode;
    logic dbg_state, dbg_owner;
    logic [CW-1:0] dbg_cnt;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_addrmode(d_addrmode),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addrmode(mem_addrmode), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_stray(err_stray),
        .o_dbg_state(dbg_state), .o_dbg_owner(dbg_owner), .o_dbg_starve_cnt(dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        if_req = 0; d_req = 0; d_we = 0; mem_ready = 0; mem_rvalid = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_addrmode = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    // Finish a granted transaction: one WAIT cycle, then a response to the given owner.
    task automatic complete_txn(input bit to_d, input string tag);
        logic [DW-1:0] r;
        r = $urandom;
        @(negedge clk);
        if_req = 0; d_req = 0; mem_rvalid = 0;
        #2 check({tag, "_wait_req"}, mem_req, 0);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = r;
        #2 check({tag, "_rvalid"}, {if_rvalid, d_rvalid}, to_d ? 2'b01 : 2'b10);
        check({tag, "_rdata"}, to_d ? d_rdata : if_rdata, r);
        check({tag, "_other_rdata"}, to_d ? if_rdata : d_rdata, 0);
        @(negedge clk);
        mem_rvalid = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic if_req, d_req, d_we, mem_ready;
        logic [AW-1:0] if_addr, d_addr;
        logic [DW-1:0] d_wdata;
        logic [2:0] mode;
        logic e_req, e_if_gnt, e_d_gnt, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [2:0] e_mode;
    } vec_t;

    vec_t tbl[7];

    // ---------------- reference model + scoreboard ----------------
    bit m_busy;
    bit m_owner_d;
    int m_cnt;
    logic [0:0] exp_q[$];

    task automatic random_run(input int cycles);
        bit win_d, grant;
        logic [0:0] tag;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if_req = ($urandom_range(0, 3) != 0);
            d_req = ($urandom_range(0, 2) != 0);
            d_we = $urandom_range(0, 1);
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_addrmode = 3'($urandom_range(0, 7));
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rvalid = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            mem_rdata = $urandom;
            #2;
            win_d = d_req && !(if_req && m_cnt == LIMIT);
            grant = !m_busy && (if_req || d_req) && mem_ready;
            check("rnd_ctl", {mem_req, if_gnt, d_gnt, err_stray},
                  {!m_busy && (if_req || d_req), grant && !win_d, grant && win_d, !m_busy && mem_rvalid});
            check("rnd_rvalid", {if_rvalid, d_rvalid},
                  {m_busy && mem_rvalid && !m_owner_d, m_busy && mem_rvalid && m_owner_d});
            check("rnd_rdata", {if_rdata, d_rdata},
                  {(m_busy && mem_rvalid && !m_owner_d) ? mem_rdata : 32'h0,
                   (m_busy && mem_rvalid && m_owner_d) ? mem_rdata : 32'h0});
            check("rnd_cnt", dbg_cnt, m_cnt);
            if (!m_busy && (if_req || d_req)) begin
                if (win_d)
                    check("rnd_fields_d", {mem_we, mem_addr, mem_wdata, mem_addrmode},
                          {d_we, d_addr, d_wdata, d_addrmode});
                else
                    check("rnd_fields_if", {mem_we, mem_addr, mem_wdata, mem_addrmode},
                          {1'b0, if_addr, 32'h0, MODE_WORD});
            end
            if (m_busy) begin
                if (mem_rvalid) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_sb_empty", 1, 0);
                    end else begin
                        tag = exp_q.pop_front();
                        check("rnd_sb_owner", {if_rvalid, d_rvalid}, tag[0] ? 2'b01 : 2'b10);
                    end
                    m_busy = 0;
                end
            end else if (grant) begin
                m_busy = 1;
                m_owner_d = win_d;
                exp_q.push_back(win_d);
                if (win_d && if_req) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
                else if (!win_d) m_cnt = 0;
            end
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int nd;
        bit got_if, pending;

        tbl[0] = '{0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0, 3'b000};
        tbl[1] = '{1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 3'b000, 1, 1, 0, 0, 32'h10, 32'h0, MODE_WORD};
        tbl[2] = '{0, 1, 0, 1, 32'h0, 32'h200, 32'h11223344, 3'b000, 1, 0, 1, 0, 32'h200, 32'h11223344, 3'b000};
        tbl[3] = '{1, 1, 1, 1, 32'h40, 32'h100, 32'hDEADBEEF, 3'b010, 1, 0, 1, 1, 32'h100, 32'hDEADBEEF, 3'b010};
        tbl[4] = '{1, 1, 1, 0, 32'h40, 32'h104, 32'hCAFEF00D, 3'b001, 1, 0, 0, 1, 32'h104, 32'hCAFEF00D, 3'b001};
        tbl[5] = '{1, 0, 1, 0, 32'h80, 32'h104, 32'h5555AAAA, 3'b101, 1, 0, 0, 0, 32'h80, 32'h0, MODE_WORD};
        tbl[6] = '{0, 1, 1, 1, 32'h80, 32'hFFFFFFFC, 32'h0000FFFF, 3'b101, 1, 0, 1, 1, 32'hFFFFFFFC, 32'h0000FFFF, 3'b101};

        // reset state, including a request pending while rst is low
        clear_inputs();
        if_req = 1; d_req = 1; mem_ready = 1;
        #2 check("reset_outputs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, err_stray, mem_addr},
                 0);
        check("reset_dbg", {dbg_state, dbg_owner, dbg_cnt}, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            if_req = tbl[i].if_req; d_req = tbl[i].d_req; d_we = tbl[i].d_we;
            mem_ready = tbl[i].mem_ready; if_addr = tbl[i].if_addr; d_addr = tbl[i].d_addr;
            d_wdata = tbl[i].d_wdata; d_addrmode = tbl[i].mode;
            #2;
            check($sformatf("tbl%0d_ctl", i), {mem_req, if_gnt, d_gnt},
                  {tbl[i].e_req, tbl[i].e_if_gnt, tbl[i].e_d_gnt});
            if (tbl[i].e_req)
                check($sformatf("tbl%0d_fields", i), {mem_we, mem_addr, mem_wdata, mem_addrmode},
                      {tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_mode});
            if (tbl[i].e_if_gnt || tbl[i].e_d_gnt)
                complete_txn(tbl[i].e_d_gnt, $sformatf("tbl%0d", i));
        end

        // fetch only, response two cycles after grant
        do_reset();
        if_req = 1; if_addr = 32'h10; mem_ready = 1;
        #2 check("t1_gnt", {if_gnt, d_gnt, mem_req, mem_we}, 4'b1010);
        @(negedge clk); if_req = 0;
        #2 check("t1_wait", {mem_req, if_rvalid, if_gnt}, 0);
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h00500093;
        #2 check("t1_rvalid", {if_rvalid, d_rvalid, err_stray}, 3'b100);
        check("t1_rdata", if_rdata, 32'h00500093);
        @(negedge clk); mem_rvalid = 0;

        // simultaneous requests: store first, fetch right after its completion
        do_reset();
        if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 1; d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF; d_addrmode = MODE_WORD; mem_ready = 1;
        #2 check("t2_dgnt", {d_gnt, if_gnt, mem_we, mem_wdata}, {3'b101, 32'hDEADBEEF});
        @(negedge clk); d_req = 0;
        #2 check("t2_wait", {mem_req, if_gnt}, 0);
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h0;
        #2 check("t2_drvalid", {d_rvalid, if_rvalid, if_gnt}, 3'b100);
        @(negedge clk); mem_rvalid = 0;
        #2 check("t2_ifgnt", {if_gnt, mem_addr, mem_we}, {1'b1, 32'h20, 1'b0});
        complete_txn(0, "t2_if");

        // starvation guard under continuous data traffic
        do_reset();
        if_req = 1; if_addr = 32'h30; d_req = 1; d_addr = 32'h400; mem_ready = 1;
        nd = 0; got_if = 0; pending = 0;
        for (int c = 0; c < 60 && !got_if; c++) begin
            if (c != 0) @(negedge clk);
            mem_rvalid = pending; pending = 0;
            #2;
            if (if_gnt) begin
                got_if = 1;
                check("t3_cnt_at_limit", dbg_cnt, LIMIT);
            end
            if (d_gnt) nd++;
            pending = if_gnt | d_gnt;
        end
        check("t3_if_won", got_if, 1);
        check("t3_d_grants", nd, LIMIT);
        @(negedge clk); if_req = 0; d_req = 0; mem_rvalid = 1;
        #2 check("t3_if_rvalid", {if_rvalid, d_rvalid}, 2'b10);
        check("t3_cnt_cleared", dbg_cnt, 0);
        @(negedge clk); mem_rvalid = 0;

        // memory not ready for three cycles
        do_reset();
        d_req = 1; d_addr = 32'h44; d_addrmode = 3'b100; mem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            #2 check($sformatf("t4_stall%0d", c), {mem_req, d_gnt, if_gnt, mem_addr, mem_addrmode},
                     {3'b100, 32'h44, 3'b100});
        end
        @(negedge clk); mem_ready = 1;
        #2 check("t4_gnt", {d_gnt, mem_addr}, {1'b1, 32'h44});
        complete_txn(1, "t4");

        // reset during WAIT, late response is stray
        do_reset();
        if_req = 1; if_addr = 32'h50; mem_ready = 1;
        #2 check("t5_gnt", if_gnt, 1);
        @(negedge clk); if_req = 0;
        #2 rst = 0;
        @(negedge clk); rst = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
        #2 check("t5_no_rvalid", {if_rvalid, d_rvalid}, 0);
        check("t5_stray", err_stray, 1);
        check("t5_idle", dbg_state, 0);
        @(negedge clk); mem_rvalid = 0;
        #2 check("t5_stray_pulse", err_stray, 0);

        // asynchronous reset in the middle of a cycle
        do_reset();
        if_req = 1; d_req = 1; d_we = 1; d_addr = 32'h88; d_wdata = 32'hFFFF0000; mem_ready = 0;
        #2 check("t6_pre", mem_req, 1);
        @(posedge clk); #2 rst = 0;
        #1 check("t6_async", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, err_stray,
                              mem_addr, mem_wdata, mem_addrmode}, 0);
        @(negedge clk); rst = 1; clear_inputs();

        // randomized traffic against the reference model
        do_reset();
        m_busy = 0; m_owner_d = 0; m_cnt = 0; exp_q.delete();
        random_run(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
